// File: rtl/mpi_pkg.sv
// mpi_pkg: shared FSM encoding, reply-delay counter type and bus inversion helpers
package mpi_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RD, S_RDRPLY, S_WR, S_WRRPLY, S_WAITEND
  } state_t;
  localparam int DLY_W = 3;
  typedef logic [DLY_W-1:0] dly_t;
  localparam logic [15:0] BUS_IDLE = 16'hFFFF;
  function automatic logic [15:0] bus_inv(input logic [15:0] v);
    return ~v;
  endfunction
endpackage

// File: rtl/mpi_ram.sv
// mpi_ram: single-port RAM with synchronous 1-clock read and two byte enables
module mpi_ram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);
  logic [7:0] lo [0:(1<<AW)-1];
  logic [7:0] hi [0:(1<<AW)-1];
  always_ff @(posedge clk)
    if (en) begin
      if (we) begin
        if (be[0]) lo[addr] <= wdata[7:0];
        if (be[1]) hi[addr] <= wdata[15:8];
      end else
        rdata <= {hi[addr], lo[addr]};
    end
endmodule

// File: rtl/mpi_ram_slave.sv
// mpi_ram_slave: Q-bus style RAM slave; define MPI_RAM_SLAVE_SYNC2_EN to add
// two-flop input synchronizers for a bus asynchronous to pin_clk.
module mpi_ram_slave
  import mpi_pkg::*;
#(
  parameter logic [15:0] ADDR_BASE = 16'o100000,
  parameter logic [15:0] ADDR_MASK = 16'o170000,
  parameter int          RPLY_DLY  = 2,
  parameter int          RAM_AW    = 11
) (
  input  logic        pin_clk,
  input  logic        pin_init_n,
  input  logic [15:0] pin_ad_n,
  output logic [15:0] pin_ad_out,
  output logic        pin_ad_ena,
  input  logic        pin_sync_n,
  input  logic        pin_din_n,
  input  logic        pin_dout_n,
  input  logic        pin_wtbt_n,
  output logic        pin_rply_n,
  output logic        sel_hit
);
  logic sync_n, din_n, dout_n, wtbt_n;
  logic [15:0] ad_n;
`ifdef MPI_RAM_SLAVE_SYNC2_EN
  logic [19:0] s1, s2;
  always_ff @(posedge pin_clk)
    if (!pin_init_n) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= {pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n, pin_ad_n};
      s2 <= s1;
    end
  assign {sync_n, din_n, dout_n, wtbt_n, ad_n} = s2;
`else
  assign {sync_n, din_n, dout_n, wtbt_n, ad_n} = {pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n, pin_ad_n};
`endif
  localparam dly_t DLY0 = dly_t'(RPLY_DLY);
  logic [15:0] ad, wdata_q, ram_q;
  logic [RAM_AW:0] addr_q;
  logic hit, byte_q, ram_en, ram_we, rply_nx, ena_nx, hit_nx;
  state_t state, state_nx;
  dly_t cnt, cnt_nx, dec;
  assign ad = bus_inv(ad_n);
  assign hit = (ad & ADDR_MASK) == (ADDR_BASE & ADDR_MASK);
  assign dec = (cnt == '0) ? '0 : cnt - 1'b1;
  assign pin_ad_out = pin_ad_ena ? bus_inv(ram_q) : BUS_IDLE;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    rply_nx = 1'b1;
    ena_nx = pin_ad_ena;
    hit_nx = sel_hit;
    ram_en = 1'b0;
    ram_we = 1'b0;
    if (sync_n) begin
      state_nx = S_IDLE;
      cnt_nx = '0;
      ena_nx = 1'b0;
      hit_nx = 1'b0;
    end else
      case (state)
        S_IDLE: begin
          state_nx = hit ? S_ADDR : S_WAITEND;
          hit_nx = hit;
        end
        S_ADDR: begin
          ena_nx = 1'b0;
          state_nx = !din_n ? S_RD : !dout_n ? S_WR : S_ADDR;
        end
        S_RD, S_WR: begin
          ram_en = 1'b1;
          ram_we = state == S_WR;
          state_nx = (state == S_RD) ? S_RDRPLY : S_WRRPLY;
          cnt_nx = DLY0;
          ena_nx = state == S_RD;
          rply_nx = DLY0 != '0;
        end
        S_RDRPLY, S_WRRPLY: begin
          // strobe release ends the reply; data enable lingers one clock via ADDR
          if ((state == S_RDRPLY) ? din_n : dout_n) begin
            state_nx = S_ADDR;
            cnt_nx = '0;
          end else begin
            cnt_nx = dec;
            rply_nx = dec != '0;
          end
        end
        default: ;
      endcase
  end
  always_ff @(posedge pin_clk)
    if (!pin_init_n) begin
      state <= S_IDLE;
      cnt <= '0;
      pin_rply_n <= 1'b1;
      pin_ad_ena <= 1'b0;
      sel_hit <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      pin_rply_n <= rply_nx;
      pin_ad_ena <= ena_nx;
      sel_hit <= hit_nx;
    end
  always_ff @(posedge pin_clk) begin
    if (state == S_IDLE && !sync_n) addr_q <= ad[RAM_AW:0];
    if (state == S_ADDR && !sync_n && din_n && !dout_n) begin
      wdata_q <= ad;
      byte_q <= !wtbt_n;
    end
  end
  // reset at the commit edge suppresses the write
  mpi_ram #(.AW(RAM_AW)) u_ram (
    .clk(pin_clk),
    .en(ram_en & pin_init_n),
    .we(ram_we),
    .be(byte_q ? {addr_q[0], !addr_q[0]} : 2'b11),
    .addr(addr_q[RAM_AW:1]),
    .wdata(wdata_q),
    .rdata(ram_q)
  );
endmodule

// File: tb/tb_mpi_ram_slave.sv
// tb_mpi_ram_slave: directed + randomized bus transactions against a word-array model
module tb_mpi_ram_slave;
  import mpi_pkg::*;
  localparam int DLY = 2;
  logic pin_clk = 0, pin_init_n = 0;
  logic [15:0] pin_ad_n = '1;
  logic pin_sync_n = 1, pin_din_n = 1, pin_dout_n = 1, pin_wtbt_n = 1;
  logic [15:0] pin_ad_out;
  logic pin_ad_ena, pin_rply_n, sel_hit;
  mpi_ram_slave #(.RPLY_DLY(DLY)) dut (
    .pin_clk(pin_clk), .pin_init_n(pin_init_n), .pin_ad_n(pin_ad_n),
    .pin_ad_out(pin_ad_out), .pin_ad_ena(pin_ad_ena), .pin_sync_n(pin_sync_n),
    .pin_din_n(pin_din_n), .pin_dout_n(pin_dout_n), .pin_wtbt_n(pin_wtbt_n),
    .pin_rply_n(pin_rply_n), .sel_hit(sel_hit)
  );
  always #5 pin_clk = ~pin_clk;
  int total = 0, bad = 0, falls = 0;
  bit chk = 0, cur_hit = 0;
  logic exp_rply = 1, exp_ena = 0, exp_hit = 0, prev_rply = 1;
  logic [15:0] exp_data = 0, cur_addr = 0, last_out = 0;
  logic [15:0] mem [2048];
  always @(negedge pin_clk) begin
    logic [15:0] want;
    if (prev_rply === 1'b1 && pin_rply_n === 1'b0) falls++;
    prev_rply = pin_rply_n;
    want = exp_ena ? ~exp_data : 16'hFFFF;
    if (chk) begin
      total++;
      if (pin_rply_n !== exp_rply || pin_ad_ena !== exp_ena || pin_ad_out !== want || sel_hit !== exp_hit) begin
        bad++;
        $display("FAIL cycle t=%0t rply=%b want %b ena=%b want %b out=%h want %h hit=%b want %b",
                 $time, pin_rply_n, exp_rply, pin_ad_ena, exp_ena, pin_ad_out, want, sel_hit, exp_hit);
      end
    end
  end
  task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge pin_clk);
    #1;
  endtask
  task automatic start(input logic [15:0] a);
    pin_ad_n = ~a;
    pin_wtbt_n = 0;
    pin_sync_n = 0;
    cyc();
    cur_addr = a;
    cur_hit = (a & 16'o170000) == 16'o100000;
    exp_hit = cur_hit;
    pin_ad_n = 16'($urandom);
    pin_wtbt_n = 1;
  endtask
  task automatic fin();
    pin_sync_n = 1;
    pin_din_n = 1;
    pin_dout_n = 1;
    pin_wtbt_n = 1;
    pin_ad_n = '1;
    cyc();
    exp_hit = 0;
    exp_ena = 0;
    exp_rply = 1;
    cyc();
  endtask
  task automatic rd(input int hold, input bit both);
    int lat;
    lat = -1;
    pin_din_n = 0;
    pin_dout_n = !both;
    cyc();
    for (int c = 1; c <= DLY + 1 + hold; c++) begin
      cyc();
      exp_data = mem[cur_addr[11:1]];
      exp_ena = cur_hit;
      exp_rply = !(cur_hit && c >= DLY + 1);
      if (c == 1) last_out = pin_ad_out;
      if (pin_rply_n === 1'b0 && lat < 0) lat = c;
    end
    pin_din_n = 1;
    pin_dout_n = 1;
    cyc();
    exp_rply = 1;
    cyc();
    exp_ena = 0;
    if (cur_hit) check("rply_latency", 16'(lat), 16'(DLY + 1));
  endtask
  task automatic wr(input logic [15:0] d, input bit bw, input int hold);
    logic [10:0] w;
    w = cur_addr[11:1];
    pin_ad_n = ~d;
    pin_wtbt_n = !bw;
    pin_dout_n = 0;
    cyc();
    pin_ad_n = 16'($urandom);
    for (int c = 1; c <= DLY + 1 + hold; c++) begin
      cyc();
      if (c == 1 && cur_hit) begin
        if (!bw) mem[w] = d;
        else if (cur_addr[0]) mem[w][15:8] = d[15:8];
        else mem[w][7:0] = d[7:0];
      end
      exp_rply = !(cur_hit && c >= DLY + 1);
    end
    pin_dout_n = 1;
    pin_wtbt_n = 1;
    cyc();
    exp_rply = 1;
  endtask
  task automatic rd_abort();
    pin_din_n = 0;
    cyc();
    for (int c = 1; c <= DLY + 1; c++) begin
      cyc();
      exp_data = mem[cur_addr[11:1]];
      exp_ena = 1;
      exp_rply = !(c >= DLY + 1);
    end
    pin_sync_n = 1;
    pin_din_n = 1;
    cyc();
    exp_rply = 1;
    exp_ena = 0;
    exp_hit = 0;
    check("abort_rply", {15'b0, pin_rply_n}, 16'd1);
    check("abort_ena", {15'b0, pin_ad_ena}, 16'd0);
    check("abort_state", 16'(dut.state), 16'(S_IDLE));
    cyc();
  endtask
  task automatic word_wr(input logic [15:0] a, input logic [15:0] d);
    start(a);
    wr(d, 0, 0);
    fin();
  endtask
  task automatic word_rd(input logic [15:0] a);
    start(a);
    rd(0, 0);
    fin();
  endtask
  function automatic logic [15:0] pick_addr();
    logic [10:0] idx;
    idx = 11'($urandom_range(0, 31)) + ($urandom_range(0, 1) ? 11'd2016 : 11'd0);
    return {4'o10, idx, 1'($urandom)};
  endfunction
  initial begin
    int f0;
    logic [15:0] a, d;
    cyc();
    cyc();
    chk = 1;
    check("rst_rply", {15'b0, pin_rply_n}, 16'd1);
    check("rst_ena", {15'b0, pin_ad_ena}, 16'd0);
    check("rst_out", pin_ad_out, 16'hFFFF);
    check("rst_hit", {15'b0, sel_hit}, 16'd0);
    pin_init_n = 1;
    cyc();
    word_wr(16'o100004, 16'o123456);
    word_rd(16'o100004);
    check("word_rd", last_out, ~16'o123456);
    word_wr(16'o100006, 16'h1234);
    start(16'o100007);
    wr(16'hA55A, 1, 0);
    fin();
    word_rd(16'o100006);
    check("byte_rd", last_out, ~16'hA534);
    word_wr(16'o100000, 16'h5555);
    f0 = falls;
    start(16'o070000);
    wr(16'hDEAD, 0, 1);
    fin();
    start(16'o070000);
    rd(1, 0);
    fin();
    check("miss_no_rply", 16'(falls - f0), 16'd0);
    word_rd(16'o100000);
    check("miss_ram_kept", last_out, ~16'h5555);
    word_wr(16'o100010, 16'h0F0F);
    f0 = falls;
    start(16'o100010);
    rd(0, 0);
    check("datio_rd", last_out, ~16'h0F0F);
    wr(16'hF0F0, 0, 0);
    fin();
    check("datio_pulses", 16'(falls - f0), 16'd2);
    word_rd(16'o100010);
    check("datio_rd_back", last_out, ~16'hF0F0);
    start(16'o100004);
    rd_abort();
    word_rd(16'o100004);
    check("after_abort", last_out, ~16'o123456);
    start(16'o100006);
    pin_ad_n = ~16'hBEEF;
    pin_dout_n = 0;
    cyc();
    pin_init_n = 0;
    cyc();
    exp_hit = 0;
    check("rstw_rply", {15'b0, pin_rply_n}, 16'd1);
    check("rstw_ena", {15'b0, pin_ad_ena}, 16'd0);
    check("rstw_out", pin_ad_out, 16'hFFFF);
    check("rstw_hit", {15'b0, sel_hit}, 16'd0);
    pin_init_n = 1;
    pin_sync_n = 1;
    pin_dout_n = 1;
    pin_ad_n = '1;
    cyc();
    word_rd(16'o100006);
    check("rstw_unchanged", last_out, ~16'hA534);
    for (int i = 0; i < 32; i++) begin
      word_wr({4'o10, 11'(i), 1'b0}, 16'($urandom));
      word_wr({4'o10, 11'(i + 2016), 1'b0}, 16'($urandom));
    end
    for (int n = 0; n < 150; n++) begin
      a = pick_addr();
      d = 16'($urandom);
      case ($urandom_range(0, 5))
        0: begin start(a); rd($urandom_range(0, 2), 1'($urandom)); fin(); end
        1: begin start(a); wr(d, 0, $urandom_range(0, 2)); fin(); end
        2: begin start(a); wr(d, 1, $urandom_range(0, 2)); fin(); end
        3: begin
          a = 16'($urandom);
          if (a[15:12] == 4'o10) a[15] = 0;
          start(a);
          if ($urandom_range(0, 1) == 1) rd(1, 0);
          else wr(d, 1'($urandom), 1);
          fin();
        end
        4: begin start(a); rd(0, 0); wr(d, 1'($urandom), 0); fin(); end
        default: begin start(a); rd_abort(); end
      endcase
    end
    chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
